// File: rtl/ap_mem_pkg.sv
// Shared constants, state encoding and helpers for the AP data cache slice.
// The line geometry and DDR window placement are fixed here for every user.
package ap_mem_pkg;

    localparam int DATA_WIDTH       = 16;
    localparam int DATA_CACHE_DEPTH = 16;
    localparam int DDR_ADDR_WIDTH   = 28;
    localparam logic [DDR_ADDR_WIDTH-1:0] DDR_DATA_BASE = 28'h0008000;
    localparam int DDR_ADDR_STRIDE  = 8;

    function automatic int lineIdxWidth(input int depth);
        return $clog2(depth);
    endfunction

    localparam int LINE_IDX_W = lineIdxWidth(DATA_CACHE_DEPTH);
    // One extra bit so the beat counter can sit at DEPTH during padding beats
    localparam int BEAT_CNT_W = LINE_IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } cache_state_t;

endpackage

// File: rtl/ap_line_ram.sv
// One cache line of storage: a synchronous write port and a registered read
// port whose output register can be cleared to zero.
module ap_line_ram
    import ap_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [LINE_IDX_W-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic                  i_rclr,
    input  logic [LINE_IDX_W-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DATA_CACHE_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage itself is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ap_data_cache_ctrl.sv
// Single-line write-back data cache between the AP load/store port and the
// DDR DATA channel: one-cycle hits, dirty write-back then refill on a miss.
module ap_data_cache_ctrl
    import ap_mem_pkg::*;
#(
    parameter int AP_ADDR_WIDTH = 16
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      ddr_rdy,
    input  logic                      core_req,
    input  logic                      core_we,
    input  logic [AP_ADDR_WIDTH-1:0]  core_addr,
    input  logic [DATA_WIDTH-1:0]     core_wdata,
    output logic                      core_ack,
    output logic [DATA_WIDTH-1:0]     core_rdata,
    output logic                      DATA_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
    input  logic [DATA_WIDTH-1:0]     DATA_to_cache,
    input  logic                      rd_burst_data_valid,
    input  logic                      rd_burst_finish,
    output logic                      DATA_store_req,
    output logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
    output logic [DATA_WIDTH-1:0]     DATA_to_ddr,
    input  logic                      wr_burst_data_req,
    input  logic                      wr_burst_finish,
    output logic                      busy
);

    localparam int TAG_W = AP_ADDR_WIDTH - LINE_IDX_W;
    localparam logic [BEAT_CNT_W-1:0] LINE_BEATS = BEAT_CNT_W'(DATA_CACHE_DEPTH);

    function automatic logic [DDR_ADDR_WIDTH-1:0] lineAddr(input logic [TAG_W-1:0] tag);
        logic [DDR_ADDR_WIDTH-1:0] wordBase;
        wordBase = DDR_ADDR_WIDTH'({tag, {LINE_IDX_W{1'b0}}});
        return DDR_DATA_BASE + wordBase * DDR_ADDR_WIDTH'(DDR_ADDR_STRIDE);
    endfunction

    cache_state_t r_state;
    cache_state_t w_stateNext;

    logic                      r_valid;
    logic                      r_dirty;
    logic                      r_ack;
    logic [TAG_W-1:0]          r_tag;
    logic [BEAT_CNT_W-1:0]     r_cnt;
    logic                      r_pendWe;
    logic [AP_ADDR_WIDTH-1:0]  r_pendAddr;
    logic [DATA_WIDTH-1:0]     r_pendWdata;
    logic [DDR_ADDR_WIDTH-1:0] r_readAddr;
    logic [DDR_ADDR_WIDTH-1:0] r_writeAddr;

    logic [LINE_IDX_W-1:0]     w_reqOff;
    logic [TAG_W-1:0]          w_reqTag;
    logic [LINE_IDX_W-1:0]     w_pendOff;
    logic [TAG_W-1:0]          w_pendTag;
    logic                      w_hit;
    logic                      w_accept;
    logic                      w_cntInLine;
    logic                      w_hitAccess;
    logic                      w_missDetect;

    logic                      w_ramWe;
    logic [LINE_IDX_W-1:0]     w_ramWaddr;
    logic [DATA_WIDTH-1:0]     w_ramWdata;
    logic                      w_ramRe;
    logic                      w_ramRclr;
    logic [LINE_IDX_W-1:0]     w_ramRaddr;
    logic [DATA_WIDTH-1:0]     w_ramRdata;

    assign w_reqOff    = core_addr[LINE_IDX_W-1:0];
    assign w_reqTag    = core_addr[AP_ADDR_WIDTH-1:LINE_IDX_W];
    assign w_pendOff   = r_pendAddr[LINE_IDX_W-1:0];
    assign w_pendTag   = r_pendAddr[AP_ADDR_WIDTH-1:LINE_IDX_W];
    assign w_hit       = r_valid && (r_tag == w_reqTag);
    // The request is still high during the ack cycle; do not serve it twice
    assign w_accept    = core_req && !r_ack;
    assign w_cntInLine = (r_cnt < LINE_BEATS);

    ap_line_ram u_lineRam (
        .clk     (mem_clk),
        .rst     (rst),
        .i_we    (w_ramWe),
        .i_waddr (w_ramWaddr),
        .i_wdata (w_ramWdata),
        .i_re    (w_ramRe),
        .i_rclr  (w_ramRclr),
        .i_raddr (w_ramRaddr),
        .o_rdata (w_ramRdata)
    );

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_hitAccess  = 1'b0;
        w_missDetect = 1'b0;
        w_ramWe      = 1'b0;
        w_ramWaddr   = w_reqOff;
        w_ramWdata   = core_wdata;
        w_ramRe      = 1'b0;
        w_ramRclr    = 1'b0;
        w_ramRaddr   = w_reqOff;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_hit) begin
                    w_hitAccess = 1'b1;
                    w_ramWe     = core_we;
                    w_ramRe     = !core_we;
                end else if (w_accept && ddr_rdy) begin
                    w_missDetect = 1'b1;
                    w_stateNext  = (r_valid && r_dirty) ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                if (wr_burst_finish) begin
                    w_stateNext = ST_FILL;
                end else if (wr_burst_data_req) begin
                    w_ramRaddr = r_cnt[LINE_IDX_W-1:0];
                    w_ramRe    = w_cntInLine;
                    w_ramRclr  = !w_cntInLine;
                end
            end
            ST_FILL: begin
                w_ramWaddr = r_cnt[LINE_IDX_W-1:0];
                w_ramWdata = DATA_to_cache;
                w_ramWe    = rd_burst_data_valid && w_cntInLine;
                if (rd_burst_finish) begin
                    w_stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                w_ramWaddr  = w_pendOff;
                w_ramWdata  = r_pendWdata;
                w_ramRaddr  = w_pendOff;
                w_ramWe     = r_pendWe;
                w_ramRe     = !r_pendWe;
                w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Line metadata, beat counter and the access captured at miss time
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_dirty     <= 1'b0;
            r_ack       <= 1'b0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_pendWe    <= 1'b0;
            r_pendAddr  <= '0;
            r_pendWdata <= '0;
            r_readAddr  <= '0;
            r_writeAddr <= '0;
        end else begin
            r_ack <= w_hitAccess || (r_state == ST_RESP);
            unique case (r_state)
                ST_IDLE: begin
                    if (w_hitAccess && core_we) begin
                        r_dirty <= 1'b1;
                    end
                    if (w_missDetect) begin
                        r_pendWe    <= core_we;
                        r_pendAddr  <= core_addr;
                        r_pendWdata <= core_wdata;
                        r_writeAddr <= lineAddr(r_tag);
                        r_readAddr  <= lineAddr(w_reqTag);
                        r_cnt       <= '0;
                    end
                end
                ST_WB: begin
                    if (wr_burst_finish) begin
                        r_dirty <= 1'b0;
                        r_cnt   <= '0;
                    end else if (wr_burst_data_req && w_cntInLine) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FILL: begin
                    if (rd_burst_finish) begin
                        r_tag   <= w_pendTag;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                    end else if (rd_burst_data_valid && w_cntInLine) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (r_pendWe) begin
                        r_dirty <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_ack        = r_ack;
    assign core_rdata      = w_ramRdata;
    assign DATA_to_ddr     = w_ramRdata;
    assign DATA_read_req   = (r_state == ST_FILL);
    assign DATA_store_req  = (r_state == ST_WB);
    assign DATA_read_addr  = r_readAddr;
    assign DATA_write_addr = r_writeAddr;
    assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ap_data_cache_ctrl.sv
// Scoreboard bench for ap_data_cache_ctrl: directed core accesses against a
// simple DDR responder, with expected acks, requests and write beats queued.
module tb_ap_data_cache_ctrl;

    typedef struct {
        bit          isLoad;
        logic [15:0] data;
    } ackExp_t;

    typedef struct {
        bit          isWrite;
        logic [27:0] addr;
    } ddrExp_t;

    logic        mem_clk;
    logic        rst;
    logic        ddr_rdy;
    logic        core_req;
    logic        core_we;
    logic [15:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_ack;
    logic [15:0] core_rdata;
    logic        DATA_read_req;
    logic [27:0] DATA_read_addr;
    logic [15:0] DATA_to_cache;
    logic        rd_burst_data_valid;
    logic        rd_burst_finish;
    logic        DATA_store_req;
    logic [27:0] DATA_write_addr;
    logic [15:0] DATA_to_ddr;
    logic        wr_burst_data_req;
    logic        wr_burst_finish;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ackExp_t     ackQ[$];
    ddrExp_t     ddrQ[$];
    logic [15:0] wbQ[$];

    logic [15:0] fillBase     = 16'h0000;
    int          fillBeats    = 17;
    bit          fillNoFinish = 1'b0;
    bit          burstStalled = 1'b0;
    ackExp_t     monExp;

    ap_data_cache_ctrl dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .ddr_rdy             (ddr_rdy),
        .core_req            (core_req),
        .core_we             (core_we),
        .core_addr           (core_addr),
        .core_wdata          (core_wdata),
        .core_ack            (core_ack),
        .core_rdata          (core_rdata),
        .DATA_read_req       (DATA_read_req),
        .DATA_read_addr      (DATA_read_addr),
        .DATA_to_cache       (DATA_to_cache),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_finish     (rd_burst_finish),
        .DATA_store_req      (DATA_store_req),
        .DATA_write_addr     (DATA_write_addr),
        .DATA_to_ddr         (DATA_to_ddr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_finish     (wr_burst_finish),
        .busy                (busy)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushDdr(input bit isWrite, input logic [27:0] addr);
        ddrExp_t e;
        e.isWrite = isWrite;
        e.addr    = addr;
        ddrQ.push_back(e);
    endtask

    task automatic startAccess(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] expData, input bit expectAck);
        ackExp_t e;
        @(posedge mem_clk);
        #1;
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        if (expectAck) begin
            e.isLoad = !we;
            e.data   = expData;
            ackQ.push_back(e);
        end
    endtask

    task automatic waitAck(output int lat);
        lat = 0;
        do begin
            @(negedge mem_clk);
            lat++;
        end while (!core_ack && lat < 500);
        if (!core_ack) checkOutput("ackTimeout", 32'd0, 32'd1);
        @(posedge mem_clk);
        #1;
        core_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] expData, output int lat);
        startAccess(we, addr, wdata, expData, 1'b1);
        waitAck(lat);
    endtask

    task automatic doReadBurst();
        for (int i = 0; i < fillBeats; i++) begin
            rd_burst_data_valid = 1'b1;
            DATA_to_cache       = fillBase + 16'(i);
            @(posedge mem_clk);
            #1;
            checkOutput("readReqHeld", 32'(DATA_read_req), 32'd1);
        end
        rd_burst_data_valid = 1'b0;
        if (fillNoFinish) begin
            burstStalled = 1'b1;
            return;
        end
        rd_burst_finish = 1'b1;
        @(posedge mem_clk);
        #1;
        rd_burst_finish = 1'b0;
    endtask

    // DATA_to_ddr is checked one cycle after each beat request was sampled
    task automatic doWriteBurst();
        logic [15:0] exp;
        for (int i = 0; i <= 16; i++) begin
            wr_burst_data_req = 1'b1;
            @(posedge mem_clk);
            #1;
            if (wbQ.size() == 0) begin
                checkOutput("wbBeatUnexpected", 32'd1, 32'd0);
            end else begin
                exp = wbQ.pop_front();
                checkOutput($sformatf("wbBeat%0d", i), 32'(DATA_to_ddr), 32'(exp));
            end
        end
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b1;
        @(posedge mem_clk);
        #1;
        wr_burst_finish = 1'b0;
    endtask

    initial begin
        ddrExp_t e;
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = 1'b0;
        wr_burst_data_req   = 1'b0;
        wr_burst_finish     = 1'b0;
        DATA_to_cache       = '0;
        forever begin
            @(posedge mem_clk);
            #1;
            if (!rst && (DATA_read_req || DATA_store_req)) begin
                if (ddrQ.size() == 0) begin
                    checkOutput("unexpectedDdrReq", 32'd1, 32'd0);
                end else begin
                    e = ddrQ.pop_front();
                    checkOutput("ddrReqIsStore", 32'(DATA_store_req), 32'(e.isWrite));
                    checkOutput("ddrReqAddr",
                                32'(DATA_store_req ? DATA_write_addr : DATA_read_addr), 32'(e.addr));
                end
                if (DATA_store_req) doWriteBurst();
                else                doReadBurst();
            end
        end
    end

    always @(negedge mem_clk) begin
        if (!rst) begin
            if (DATA_read_req || DATA_store_req)
                checkOutput("reqExclusive", 32'(DATA_read_req & DATA_store_req), 32'd0);
            if (core_ack) begin
                if (ackQ.size() == 0) begin
                    checkOutput("unexpectedAck", 32'd1, 32'd0);
                end else begin
                    monExp = ackQ.pop_front();
                    if (monExp.isLoad) checkOutput("loadData", 32'(core_rdata), 32'(monExp.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        rst        = 1'b1;
        ddr_rdy    = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        repeat (3) @(posedge mem_clk);
        @(negedge mem_clk);
        checkOutput("rstAck",       32'(core_ack), 32'd0);
        checkOutput("rstRdata",     32'(core_rdata), 32'd0);
        checkOutput("rstBusy",      32'(busy), 32'd0);
        checkOutput("rstReadReq",   32'(DATA_read_req), 32'd0);
        checkOutput("rstStoreReq",  32'(DATA_store_req), 32'd0);
        checkOutput("rstReadAddr",  32'(DATA_read_addr), 32'd0);
        checkOutput("rstWriteAddr", 32'(DATA_write_addr), 32'd0);
        checkOutput("rstToDdr",     32'(DATA_to_ddr), 32'd0);
        @(posedge mem_clk);
        #1;
        rst = 1'b0;

        $display("[TB] cold load miss with 17-beat refill");
        fillBase = 16'h1000;
        pushDdr(1'b0, 28'h0008100);
        applyStimulus(1'b0, 16'h0023, 16'h0000, 16'h1003, lat);

        $display("[TB] load hits on the filled line");
        applyStimulus(1'b0, 16'h0025, 16'h0000, 16'h1005, lat);
        checkOutput("hitLatencyLoad", 32'(lat), 32'd2);
        applyStimulus(1'b0, 16'h0020, 16'h0000, 16'h1000, lat);
        applyStimulus(1'b0, 16'h002F, 16'h0000, 16'h100F, lat);

        $display("[TB] store hit then dirty miss");
        applyStimulus(1'b1, 16'h0027, 16'hBEEF, 16'h0000, lat);
        checkOutput("hitLatencyStore", 32'(lat), 32'd2);
        applyStimulus(1'b0, 16'h0027, 16'h0000, 16'hBEEF, lat);
        pushDdr(1'b1, 28'h0008100);
        pushDdr(1'b0, 28'h0008200);
        for (int i = 0; i < 16; i++) wbQ.push_back((i == 7) ? 16'hBEEF : 16'h1000 + 16'(i));
        wbQ.push_back(16'h0000);
        fillBase = 16'h2000;
        applyStimulus(1'b0, 16'h0047, 16'h0000, 16'h2007, lat);

        $display("[TB] miss held off while DDR not ready");
        @(posedge mem_clk);
        #1;
        ddr_rdy  = 1'b0;
        fillBase = 16'h3000;
        pushDdr(1'b0, 28'h0008300);
        startAccess(1'b0, 16'h0063, 16'h0000, 16'h3003, 1'b1);
        repeat (10) begin
            @(negedge mem_clk);
            checkOutput("notRdyIdle", 32'({busy, DATA_read_req, DATA_store_req}), 32'd0);
        end
        @(posedge mem_clk);
        #1;
        ddr_rdy = 1'b1;
        @(negedge mem_clk);
        checkOutput("reqSameCycleAsRdy", 32'(DATA_read_req), 32'd0);
        @(negedge mem_clk);
        checkOutput("reqCycleAfterRdy", 32'(DATA_read_req), 32'd1);
        waitAck(lat);

        $display("[TB] reset in the middle of a refill");
        fillBase     = 16'h5000;
        fillBeats    = 5;
        fillNoFinish = 1'b1;
        burstStalled = 1'b0;
        pushDdr(1'b0, 28'h0008400);
        startAccess(1'b0, 16'h0085, 16'h0000, 16'h0000, 1'b0);
        n = 0;
        while (!burstStalled && n < 200) begin
            @(negedge mem_clk);
            n++;
        end
        checkOutput("fillReqBeforeReset", 32'(DATA_read_req), 32'd1);
        rst      = 1'b1;
        core_req = 1'b0;
        #1;
        checkOutput("readReqOnReset", 32'(DATA_read_req), 32'd0);
        checkOutput("busyOnReset", 32'(busy), 32'd0);
        @(posedge mem_clk);
        #1;
        rst          = 1'b0;
        fillNoFinish = 1'b0;
        fillBeats    = 17;
        burstStalled = 1'b0;
        fillBase     = 16'h4000;
        pushDdr(1'b0, 28'h0008400);
        applyStimulus(1'b0, 16'h0085, 16'h0000, 16'h4005, lat);

        $display("[TB] core drops request during write-back");
        applyStimulus(1'b1, 16'h0081, 16'hCAFE, 16'h0000, lat);
        pushDdr(1'b1, 28'h0008400);
        pushDdr(1'b0, 28'h0008500);
        for (int i = 0; i < 16; i++) wbQ.push_back((i == 1) ? 16'hCAFE : 16'h4000 + 16'(i));
        wbQ.push_back(16'h0000);
        fillBase = 16'h6000;
        startAccess(1'b0, 16'h00A2, 16'h0000, 16'h6002, 1'b1);
        n = 0;
        while (!DATA_store_req && n < 100) begin
            @(negedge mem_clk);
            n++;
        end
        checkOutput("wbStarted", 32'(DATA_store_req), 32'd1);
        @(posedge mem_clk);
        #1;
        core_req   = 1'b0;
        core_we    = 1'b1;
        core_addr  = 16'hFFFF;
        core_wdata = 16'h0BAD;
        waitAck(lat);
        repeat (3) @(negedge mem_clk);
        checkOutput("idleAfterDrop", 32'(busy), 32'd0);
        applyStimulus(1'b0, 16'h00A2, 16'h0000, 16'h6002, lat);
        checkOutput("hitLatencyAfterDrop", 32'(lat), 32'd2);
        applyStimulus(1'b0, 16'h00AF, 16'h0000, 16'h600F, lat);

        repeat (20) @(negedge mem_clk);
        checkOutput("ackQueueDrained", 32'(ackQ.size()), 32'd0);
        checkOutput("ddrQueueDrained", 32'(ddrQ.size()), 32'd0);
        checkOutput("wbQueueDrained",  32'(wbQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_data_cache_ctrl.md
Name: ap_data_cache_ctrl

Overview:
- Single-line write-back data cache controller between the AP core's load/store port and the DDR cache interface's DATA channel.
- Holds one DATA_CACHE_DEPTH-word line with a tag, a valid bit and a dirty bit.
- Serves hits in one cycle.
- On a miss, writes back the dirty line through DATA_store_req, then refills through DATA_read_req.

Parameters:
- DATA_WIDTH, 16, AP data word width.
- DATA_CACHE_DEPTH, 16, words per line; power of two, ≥ 2.
- AP_ADDR_WIDTH, 16, core word address width.
- DDR_ADDR_WIDTH, 28, DDR address width.
- DDR_DATA_BASE, 28'h0008000, DDR address of AP word 0.
- DDR_ADDR_STRIDE, 8, DDR address units per 128-bit beat.

Ports:
- mem_clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ddr_rdy  in  1  DDR interface initialised; no request is issued while 0.
- core_req  in  1  core access request; held until core_ack.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  AP_ADDR_WIDTH  word address.
- core_wdata  in  DATA_WIDTH  store data.
- core_ack  out  1  one-cycle completion pulse.
- core_rdata  out  DATA_WIDTH  load data, valid with core_ack.
- DATA_read_req  out  1  refill burst request.
- DATA_read_addr  out  DDR_ADDR_WIDTH  refill DDR address.
- DATA_to_cache  in  DATA_WIDTH  refill beat data.
- rd_burst_data_valid  in  1  refill beat valid.
- rd_burst_finish  in  1  refill burst done.
- DATA_store_req  out  1  write-back burst request.
- DATA_write_addr  out  DDR_ADDR_WIDTH  write-back DDR address.
- DATA_to_ddr  out  DATA_WIDTH  write-back beat data.
- wr_burst_data_req  in  1  DDR interface wants the next write beat.
- wr_burst_finish  in  1  write-back burst done.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (async):
  - Outputs: core_ack = 0, core_rdata = 0, DATA_read_req = 0, DATA_store_req = 0, both DDR addresses = 0, DATA_to_ddr = 0, busy = 0.
  - Internal: state = IDLE, valid = 0, dirty = 0, tag = 0, beat counter = 0.
  - Line RAM contents are not reset.
- Address split: off = core_addr[log2(DEPTH)-1:0]; tag = remaining upper bits.
- Line DDR address = DDR_DATA_BASE + {tag, log2(DEPTH) zeros} * DDR_ADDR_STRIDE, truncated to DDR_ADDR_WIDTH.
- State machine:
  - IDLE
    - core_req & hit (valid & tag match):
      - Load: core_rdata = line[off].
      - Store: line[off] = core_wdata; dirty = 1.
      - core_ack pulses the next cycle; stay in IDLE.
    - core_req & miss & ddr_rdy: go to WB if valid & dirty, else FILL.
    - Miss with ddr_rdy = 0: wait in IDLE with no request issued.
  - WB
    - DATA_store_req = 1 and DATA_write_addr = old line address, both held until wr_burst_finish.
    - On each wr_burst_data_req: DATA_to_ddr = line[cnt] registered (one-cycle latency); cnt increments.
    - For cnt ≥ DEPTH, DATA_to_ddr = 0. The DDR side bursts DEPTH+1 beats; extra beats are zero padding.
    - On wr_burst_finish: deassert the request, dirty = 0, cnt = 0, go to FILL.
  - FILL
    - DATA_read_req = 1 and DATA_read_addr = new line address, held until rd_burst_finish.
    - On each rd_burst_data_valid with cnt < DEPTH: line[cnt] = DATA_to_cache; cnt increments.
    - Valid beats with cnt ≥ DEPTH are discarded.
    - On rd_burst_finish: deassert the request, tag = new tag, valid = 1, cnt = 0, go to RESP.
  - RESP: re-execute the pending access as a hit (store sets dirty) and pulse core_ack; go to IDLE.
- Hit latency: 1 cycle. Clean miss: fill duration + 2. Dirty miss: write-back + fill + 2.
- core_addr, core_we and core_wdata are latched at miss detection; core changes during busy are ignored.
- A rd_burst_finish that arrives with fewer than DEPTH valid beats still completes the fill; words not received keep their old contents.
- Never assert DATA_read_req and DATA_store_req in the same cycle.
- core_req deasserted mid-miss: the miss completes anyway; core_ack still pulses.
- Reset mid-burst: requests drop immediately and the line is invalidated.
- wr_burst_finish and wr_burst_data_req in the same cycle: treat as finish; no further beat.

Decomposition:
- Shared package ap_mem_pkg:
  - Constants: DATA_WIDTH, DATA_CACHE_DEPTH, DDR_ADDR_WIDTH, DDR_DATA_BASE, DDR_ADDR_STRIDE.
  - State encoding localparams.
  - Line-index width function.
- One natural sub-module: ap_line_ram, a DEPTH × DATA_WIDTH register file.
  - One synchronous write port, muxed between core store and refill.
  - One registered read port, muxed between core load and write-back counter.

Test Plan:
1. Cold load addr 0x0023, ddr_rdy = 1 -> FILL.
   - Required: DATA_read_req with DATA_read_addr = 0x0008000 + 0x20*8 = 0x0008100; no DATA_store_req.
   - Feed 17 beats 0x1000..0x1010 -> core_ack with core_rdata = 0x1003; beat 17 ignored.
2. Load 0x0025 after scenario 1 -> core_ack exactly 1 cycle after core_req, rdata = 0x1005, no DDR request.
3. Store 0x0027 = 0xBEEF (hit), then load 0x0047 (miss) -> WB.
   - Required: DATA_write_addr = 0x0008100; DATA_to_ddr beat 7 = 0xBEEF, one cycle after the 8th wr_burst_data_req; beat 16 = 0.
   - Then FILL at 0x0008200.
4. Miss with ddr_rdy = 0 for 10 cycles -> no request and busy = 0 throughout; a request is issued the cycle after ddr_rdy rises.
5. Assert rst during FILL after 5 beats -> DATA_read_req = 0 immediately; next load to the same address misses again.
6. Drop core_req during WB -> WB and FILL both complete, a single core_ack pulse occurs, and state ends in IDLE.
